decoder_scan_seq: RTL
=====================

// Module: decoder_scan_seq
// PURPOSE
//   Parametrised registered N-to-2^N one-hot decoder with enable, plus an
//   auto-scan mode that walks the one-hot output across all lines with a
//   programmable dwell. Drives row/digit selects and chip-select fan-out.
//   DIRECT mode gives a registered decode of a select bus. SCAN mode is an
//   FSM-driven sweep.
// PARAMETERS
//   SEL_W    3   select width; NOUT = 2**SEL_W output lines
//   DWELL_W  4   width of dwell count; each line held dwell+1 cycles in SCAN
// PORTS
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous reset, active-high
//   en     in   1        global enable; 0 forces d to all-zero
//   mode   in   1        0 = DIRECT, 1 = SCAN
//   sel    in   SEL_W    line select, DIRECT mode
//   dwell  in   DWELL_W  dwell count, sampled on accepted start
//   start  in   1        single-cycle scan start request
//   d      out  NOUT     one-hot decoded lines; d[k] high selects line k
//   idx    out  SEL_W    index of currently asserted line
//   busy   out  1        high while in SCAN state
//   wrap   out  1        one-cycle flag on the last cycle of line NOUT-1
// BEHAVIOUR
//   - All outputs are registered. Reset values: d=0, idx=0, busy=0, wrap=0,
//     state=IDLE, dwell counter=0. rst overrides every other input.
//   - FSM states: IDLE, DIRECT, SCAN.
//     * any state, en=0 -> IDLE; next cycle d=0, busy=0, wrap=0
//     * IDLE/DIRECT, en=1, mode=0 -> DIRECT
//     * IDLE/DIRECT, en=1, mode=1, start=1 -> SCAN
//     * SCAN, mode=0 (en=1) -> DIRECT; scan aborted, no wrap
//   - DIRECT: d <= 1<<sel, idx <= sel. One-cycle latency; tracks sel each cycle.
//   - IDLE: d=0, idx holds last value.
//     In IDLE/DIRECT with mode=1 and start=0, remain/enter IDLE (d=0).
//   - SCAN entry (start accepted at edge t):
//     * at t+1: d=1<<0, idx=0, busy=1
//     * dwell counter loaded with sampled dwell
//   - SCAN step:
//     * counter decrements each cycle
//     * at 0, idx increments; counter reloads the stored dwell
//     * line k held for exactly dwell+1 cycles
//   - wrap=1 exactly while idx==NOUT-1 and counter==0, aligned with d.
//   - After line NOUT-1, idx wraps to 0 and scanning continues (see
//     CONFIGURATION).
//   - start while busy: ignored. Dwell changes mid-scan: ignored until next
//     accepted start.
//   - dwell=0: one line per cycle; wrap every NOUT cycles.
//   - sel is ignored in SCAN. start is ignored when en=0 or mode=0.
//   - Exactly one bit of d is high whenever state is DIRECT or SCAN.
// CONFIGURATION
//   DECODE_ONESHOT_EN
//     defined:
//       * scan performs a single sweep
//       * the cycle after the wrap cycle: state=IDLE, d=0, busy=0, idx=0
//       * a new start is required to sweep again
//     undefined:
//       * scan is free-running; it wraps from line NOUT-1 to line 0 with
//         no gap cycle
//       * it runs until en=0 or mode=0
// TESTING (SEL_W=3, DWELL_W=4 unless stated)
//   1 reset: rst=1 for 2 cycles, en=1, mode=0, sel=5
//       -> d=8'h00, idx=0, busy=0, wrap=0
//   2 direct sweep: en=1, mode=0, sel=0..7 on consecutive cycles
//       -> each cycle later d=8'h01,02,...,80
//       -> drop en: next cycle d=8'h00
//   3 free scan, macro undefined: dwell=2, start at edge t
//       -> d=8'h01 on t+1..t+3; d=8'h02 on t+4..t+6
//       -> d=8'h80 on t+22..t+24 with wrap=1 only at t+24
//       -> d=8'h01 again at t+25
//   4 one-shot, macro defined: same stimulus as 3
//       -> identical through t+24
//       -> t+25: d=8'h00, busy=0, idx=0; no further activity without start
//   5 abort/restart: scan as in 3
//       -> en=0 at t+5: t+6 d=8'h00, busy=0
//       -> en=1, start: sweep restarts from line 0
//       -> mode=0 mid-scan: next cycle d=1<<sel
//   6 dwell=0 plus start during busy
//       -> d steps one line per cycle, wrap every 8th cycle
//       -> extra start mid-sweep does not reset idx
//   7 SEL_W=4: dwell=0 free scan
//       -> 16 one-hot patterns, wrap period 16 cycles

Source files
------------

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot decoder with direct and auto-scan modes.
// Optional DECODE_ONESHOT_EN: scan stops after a single sweep.
module decoder_scan_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic                    start,
    output logic [(1<<SEL_W)-1:0]   d,
    output logic [SEL_W-1:0]        idx,
    output logic                    busy,
    output logic                    wrap
);

    localparam int NOUT = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t               state_q, state_n;
    logic [NOUT-1:0]      d_q, d_n;
    logic [SEL_W-1:0]     idx_q, idx_n;
    logic                 busy_q, busy_n;
    logic                 wrap_q, wrap_n;
    logic [DWELL_W-1:0]   cnt_q, cnt_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;

    function automatic logic [NOUT-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_n;
            d_q     <= d_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            wrap_q  <= wrap_n;
            cnt_q   <= cnt_n;
            dwell_q <= dwell_n;
        end
    end

    always_comb begin
        state_n = state_q;
        d_n     = d_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        cnt_n   = cnt_q;
        dwell_n = dwell_q;
        if (!en) begin
            state_n = IDLE;
            d_n     = '0;
            busy_n  = 1'b0;
        end else if (state_q == SCAN && mode) begin
            // start is ignored here: a running sweep keeps its dwell
            busy_n = 1'b1;
            if (cnt_q != '0) begin
                cnt_n = cnt_q - DWELL_W'(1);
            end else begin
                cnt_n = dwell_q;
                idx_n = idx_q + SEL_W'(1);
                d_n   = onehot(idx_n);
`ifdef DECODE_ONESHOT_EN
                if (idx_q == LAST_IDX) begin
                    state_n = IDLE;
                    d_n     = '0;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                end
`endif
            end
        end else if (!mode) begin
            state_n = DIRECT;
            d_n     = onehot(sel);
            idx_n   = sel;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = SCAN;
            d_n     = onehot('0);
            idx_n   = '0;
            busy_n  = 1'b1;
            cnt_n   = dwell;
            dwell_n = dwell;
        end else begin
            state_n = IDLE;
            d_n     = '0;
            busy_n  = 1'b0;
        end
        // registered alongside d so the flag lines up with the last line
        wrap_n = (state_n == SCAN) && (idx_n == LAST_IDX) && (cnt_n == '0);
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule
